// File: rtl/comparator_checker.sv
// Self-test sequencer for an eq/gt magnitude comparator: sweeps every {b,a}
// pair, checks the sampled result against a golden model and logs failures.
module comparator_checker #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2
) (
  input  logic             CLK100MHZ,
  input  logic             RST,
  input  logic             start,
  input  logic             stop_on_fail,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic             eq_in,
  input  logic             gt_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [2*WIDTH-1:0] r_v;
  logic [3:0]         r_settle;
  logic               r_stop;
  logic [15:0]        r_err;
  logic [WIDTH-1:0]   r_fail_a;
  logic [WIDTH-1:0]   r_fail_b;

  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic               w_start_ok;
  logic               w_settle_end;
  logic               w_mismatch;
  logic               w_last;

  assign w_a          = r_v[WIDTH-1:0];
  assign w_b          = r_v[2*WIDTH-1:WIDTH];
  assign w_start_ok   = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_settle_end = (r_settle == 4'(SETTLE - 1));
  assign w_last       = &r_v;
  // Comparator inputs only matter in CHECK; one vector counts once even if both bits are wrong.
  assign w_mismatch   = (r_state == S_CHECK) &&
                        ((eq_in != (w_a == w_b)) || (gt_in != (w_a > w_b)));

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_DRIVE;
      S_DRIVE:        if (w_settle_end) w_next = S_CHECK;
      S_CHECK:        if ((w_mismatch && r_stop) || w_last) w_next = S_DONE;
                      else w_next = S_DRIVE;
      default:        w_next = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_v      <= '0;
      r_settle <= '0;
      r_stop   <= 1'b0;
      r_err    <= '0;
      r_fail_a <= '0;
      r_fail_b <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_ok) begin
        r_v      <= '0;
        r_settle <= '0;
        r_stop   <= stop_on_fail;
        r_err    <= '0;
        r_fail_a <= '0;
        r_fail_b <= '0;
      end else if (r_state == S_DRIVE) begin
        r_settle <= w_settle_end ? 4'd0 : r_settle + 4'd1;
      end else if (r_state == S_CHECK) begin
        if (w_mismatch) begin
          if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
          if (r_err == 16'd0) begin
            r_fail_a <= w_a;
            r_fail_b <= w_b;
          end
        end
        // The index only advances back into DRIVE, so it never rolls over mid-sweep.
        if (w_next == S_DRIVE) r_v <= r_v + 1'b1;
      end
    end
  end

  assign a         = w_a;
  assign b         = w_b;
  assign busy      = (r_state == S_DRIVE) || (r_state == S_CHECK);
  assign done      = (r_state == S_DONE);
  assign pass      = done && (r_err == 16'd0);
  assign err_count = r_err;
  assign fail_a    = r_fail_a;
  assign fail_b    = r_fail_b;

endmodule

// File: tb/tb_comparator_checker.sv
// Directed bench for comparator_checker with a selectable faulty comparator
// model; WIDTH=4 keeps each sweep at 256 vectors * 3 cycles = 768 cycles.
module tb_comparator_checker;

  localparam int WIDTH  = 4;
  localparam int SETTLE = 2;
  localparam int SWEEP  = (1 << (2 * WIDTH)) * (SETTLE + 1);

  typedef enum int {M_IDEAL, M_GT0, M_EQ0, M_SWAP} mode_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop_on_fail = 1'b0;
  logic [WIDTH-1:0] a, b, fail_a, fail_b;
  logic             eq_in, gt_in, busy, done, pass;
  logic [15:0]      err_count;
  mode_t            mode = M_IDEAL;

  int checks = 0;
  int errors = 0;

  comparator_checker #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .CLK100MHZ(clk), .RST(rst), .start(start), .stop_on_fail(stop_on_fail),
    .a(a), .b(b), .eq_in(eq_in), .gt_in(gt_in), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .fail_a(fail_a), .fail_b(fail_b)
  );

  always #5 clk = ~clk;

  // Comparator under test, with injectable faults.
  always_comb begin
    eq_in = (a == b);
    gt_in = (a > b);
    case (mode)
      M_GT0:   gt_in = 1'b0;
      M_EQ0:   eq_in = 1'b0;
      M_SWAP:  gt_in = (b > a);
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Returns at a negedge with done high (or budget exhausted); counts busy cycles.
  task automatic wait_sweep(output int n);
    n = 0;
    for (int i = 0; i < 4 * SWEEP; i++) begin
      if (done) break;
      if (busy) n++;
      @(negedge clk);
    end
    check("sweep_done", done, 1);
  endtask

  initial begin
    int n;
    int cyc;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    rst = 1'b0;

    // 1: ideal comparator, full clean sweep
    mode = M_IDEAL;
    pulse_start();
    wait_sweep(n);
    check("t1_busy_cycles", n, SWEEP);
    check("t1_pass", pass, 1);
    check("t1_err", err_count, 0);
    check("t1_fail_a", fail_a, 0);
    check("t1_fail_b", fail_b, 0);

    // 2: gt stuck at 0 -> every a>b pair fails (16*15/2 = 120)
    mode = M_GT0;
    pulse_start();
    wait_sweep(n);
    check("t2_busy_cycles", n, SWEEP);
    check("t2_err", err_count, 120);
    check("t2_fail_a", fail_a, 1);
    check("t2_fail_b", fail_b, 0);
    check("t2_pass", pass, 0);

    // Re-arm from DONE clears results immediately, rerun is clean
    mode = M_IDEAL;
    pulse_start();
    check("rearm_err", err_count, 0);
    check("rearm_fail_a", fail_a, 0);
    check("rearm_done", done, 0);
    check("rearm_busy", busy, 1);
    wait_sweep(n);
    check("rearm_pass", pass, 1);

    // 3: eq stuck at 0 -> the 16 diagonal pairs fail, first at {0,0}
    mode = M_EQ0;
    pulse_start();
    wait_sweep(n);
    check("t3_err", err_count, 16);
    check("t3_fail_a", fail_a, 0);
    check("t3_fail_b", fail_b, 0);

    // 4: gt swapped with stop_on_fail -> halts on vector 1
    mode = M_SWAP;
    stop_on_fail = 1'b1;
    pulse_start();
    stop_on_fail = 1'b0;
    cyc = 1;
    while (!done && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_done_cycle", cyc, 7);
    check("t4_err", err_count, 1);
    check("t4_fail_a", fail_a, 1);
    check("t4_fail_b", fail_b, 0);
    check("t4_hold_a", a, 1);
    check("t4_hold_b", b, 0);
    check("t4_busy", busy, 0);

    // 6: start while busy is ignored (no restart, no clear)
    mode = M_GT0;
    pulse_start();
    n = 1;
    for (int i = 0; i < 4 * SWEEP && !done; i++) begin
      start = (i == 300);
      @(negedge clk);
      if (busy) n++;
    end
    start = 1'b0;
    check("t6_busy_cycles", n, SWEEP);
    check("t6_err", err_count, 120);

    // 5: reset mid-sweep wins over a simultaneous start
    pulse_start();
    repeat (100) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_err", err_count, 0);
    check("t5_fail_a", fail_a, 0);
    check("t5_fail_b", fail_b, 0);
    check("t5_a", a, 0);
    check("t5_b", b, 0);
    @(negedge clk);
    check("t5_idle_busy", busy, 0);
    mode = M_IDEAL;
    pulse_start();
    wait_sweep(n);
    check("t5_busy_cycles", n, SWEEP);
    check("t5_pass", pass, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comparator_checker.md
Name: comparator_checker

Overview:
- Self-checking stimulus sequencer for the MSB-first eight-bit magnitude comparator (eq/gt outputs).
- Drives every operand pair {b,a} to the comparator and samples its eq/gt after a settle window.
- Compares each result against an internal golden model, counts mismatches and captures the first failing pair.
- Sits on-board beside the comparator in place of the switches, for bring-up and ILA-visible self-test.

Parameters:
- WIDTH, 8, operand width in bits; the sweep covers 2^(2*WIDTH) vectors.
- SETTLE, 2, cycles each vector is held before sampling; legal range 1..15.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz.
- RST  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; starts a sweep when the block is idle or done.
- stop_on_fail  input  1  when 1, the sweep halts on the first mismatch; sampled at start.
- a  output  WIDTH  operand A to the comparator.
- b  output  WIDTH  operand B to the comparator.
- eq_in  input  1  comparator result; 1 means a==b.
- gt_in  input  1  comparator result; 1 means a>b (unsigned).
- busy  output  1  high while a sweep is in progress.
- done  output  1  sticky high after a sweep completes or halts; cleared by the next accepted start.
- pass  output  1  high when done==1 and err_count==0.
- err_count  output  16  number of mismatching vectors; saturates at 16'hFFFF.
- fail_a  output  WIDTH  a of the first mismatch; 0 if no mismatch has occurred.
- fail_b  output  WIDTH  b of the first mismatch; 0 if no mismatch has occurred.

Behaviour:
- Reset:
  - All outputs go to 0 and the state goes to IDLE.
  - Reset has priority over everything, including mid-sweep.
  - No partial results are retained after reset.
- States: IDLE, DRIVE, CHECK, DONE.
- IDLE:
  - a=b=0 and busy=0.
  - start=1 clears err_count, fail_a, fail_b and done, latches stop_on_fail, loads vector index v=0, and moves to DRIVE.
- DRIVE:
  - {b,a} = v, with a in the low WIDTH bits, so a increments fastest.
  - busy=1.
  - The state holds for exactly SETTLE cycles, using an internal settle counter.
  - It then moves to CHECK.
- CHECK (one cycle):
  - Expected values: exp_eq = (a==b), exp_gt = (a>b), both unsigned.
  - A mismatch occurs when eq_in != exp_eq or gt_in != exp_gt. A vector counts once even if both bits are wrong.
  - On a mismatch, err_count increments and saturates at 16'hFFFF.
  - On the first mismatch only, fail_a and fail_b capture a and b.
  - Next state:
    - If a mismatch occurred and stop_on_fail is latched, go to DONE.
    - Else if v is the all-ones index, go to DONE.
    - Else increment v and go to DRIVE.
- DONE:
  - done=1 and busy=0.
  - a and b hold their last driven values.
  - start=1 re-arms exactly as from IDLE.
- Timing:
  - Cost per vector is SETTLE+1 cycles.
  - A full sweep takes 2^(2*WIDTH)*(SETTLE+1) cycles from the first DRIVE cycle.
  - The first DRIVE cycle is the cycle after start is sampled.
  - done rises on the cycle after the final CHECK.
- Boundary rules:
  - start while busy is ignored.
  - start in the same cycle as RST is ignored, because reset wins.
  - eq_in and gt_in are ignored outside CHECK.
  - The vector index wraps only via DONE; v never rolls over inside a sweep.
  - pass is combinational from done and err_count.

Test Plan:
1. Ideal comparator model, WIDTH=8, SETTLE=2, start pulse -> busy for 196608 cycles, then done=1, pass=1, err_count=0, fail_a=fail_b=0.
2. gt_in stuck at 0, stop_on_fail=0 -> err_count=32640, fail_a=1, fail_b=0, pass=0.
3. eq_in stuck at 0 -> err_count=256, fail_a=0, fail_b=0.
4. gt_in computed as b>a, stop_on_fail=1 -> halts at vector 1:
   - done=1 at cycle 7 after start.
   - err_count=1, fail_a=1, fail_b=0.
   - a=1 and b=0 remain held.
5. RST asserted at cycle 1000 of a sweep -> the next cycle shows every output at 0 and the state in IDLE. A following start runs a full clean sweep with the ideal model (pass=1).
6. start re-pulsed while busy -> ignored, with no restart and no count clear. start in DONE after test 2 -> err_count and fail_* cleared, and the sweep reruns.
